// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D line-request arbiter in front of the physical memory port.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the instruction, data and physical memory line ports around the arbiter.
// master = surrounding system (caches + memory), slave = the arbiter itself.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  imem_read;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [LINE_WIDTH-1:0] imem_rdata;
  logic                  imem_resp;

  logic                  dmem_read;
  logic                  dmem_write;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [LINE_WIDTH-1:0] dmem_wdata;
  logic [LINE_WIDTH-1:0] dmem_rdata;
  logic                  dmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output imem_read, imem_address,
    output dmem_read, dmem_write, dmem_address, dmem_wdata,
    output pmem_rdata, pmem_resp,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  imem_read, imem_address,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata,
    input  pmem_rdata, pmem_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Serialises I-side and D-side cache-line transactions onto one memory port, one at a time.
// Data wins ties, but only MAX_D_BURST times in a row while the instruction side waits.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int MAX_D_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_D_BURST);

  state_t                state_q, state_d;
  gnt_t                  gnt_q, gnt_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      d_cnt_q, d_cnt_d;
  logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
  logic [LINE_WIDTH-1:0] drdata_q, drdata_d;

  logic d_req;
  logic any_req;
  gnt_t pick_gnt;

  always_comb begin : pick
    d_req   = bus.dmem_read | bus.dmem_write;
    any_req = bus.imem_read | d_req;
    if (bus.imem_read && d_req) begin
      pick_gnt = (d_cnt_q == CNT_MAX) ? GNT_I : GNT_D;
    end else if (d_req) begin
      pick_gnt = GNT_D;
    end else begin
      pick_gnt = GNT_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_I;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      d_cnt_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      d_cnt_q  <= d_cnt_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    d_cnt_d  = d_cnt_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          if (pick_gnt == GNT_D) begin
            // A simultaneous read+write request is resolved as a write.
            op_d    = bus.dmem_write ? OP_WRITE : OP_READ;
            addr_d  = bus.dmem_address;
            wdata_d = bus.dmem_wdata;
            if (!bus.imem_read) begin
              d_cnt_d = '0;
            end else if (d_cnt_q != CNT_MAX) begin
              d_cnt_d = d_cnt_q + CNT_W'(1);
            end
          end else begin
            op_d    = OP_READ;
            addr_d  = bus.imem_address;
            d_cnt_d = '0;
          end
        end
      end
      BUSY: begin
        if (bus.pmem_resp) begin
          state_d = RESP;
          if (gnt_q == GNT_I) begin
            irdata_d = bus.pmem_rdata;
          end else begin
            drdata_d = bus.pmem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is decoded from registers only, so nothing flows through combinationally.
  always_comb begin : outputs
    bus.pmem_read    = (state_q == BUSY) && (op_q == OP_READ);
    bus.pmem_write   = (state_q == BUSY) && (op_q == OP_WRITE);
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.imem_resp    = (state_q == RESP) && (gnt_q == GNT_I);
    bus.dmem_resp    = (state_q == RESP) && (gnt_q == GNT_D);
    bus.imem_rdata   = irdata_q;
    bus.dmem_rdata   = drdata_q;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed requester traffic against a latency-programmable memory model.
module tb_pmem_arbiter;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_D_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          side;      // 0 = I, 1 = D
    bit          chk_data;
    logic [LW-1:0] data;
  } resp_exp_t;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int          len;       // expected cycles with request high, 0 = not checked
  } pm_exp_t;

  resp_exp_t resp_q[$];
  pm_exp_t   pm_q[$];

  int checks = 0;
  int errors = 0;
  int mem_lat = 10;
  bit stray_req = 1'b0;
  logic [LW-1:0] mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] fill(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic bad_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  task automatic wait_resp(input bit side);
    int n = 0;
    bit seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      seen = side ? bus.dmem_resp : bus.imem_resp;
    end while (!seen && n < 300);
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no resp in %0d cycles, required one", side ? "d" : "i", n);
    end
  endtask

  task automatic i_txn(input logic [AW-1:0] a);
    bus.imem_read    = 1'b1;
    bus.imem_address = a;
    wait_resp(1'b0);
    bus.imem_read    = 1'b0;
  endtask

  task automatic d_txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
    bus.dmem_read    = rd;
    bus.dmem_write   = wr;
    bus.dmem_address = a;
    bus.dmem_wdata   = w;
    wait_resp(1'b1);
    bus.dmem_read    = 1'b0;
    bus.dmem_write   = 1'b0;
  endtask

  // Memory model: responds mem_lat cycles after it first sees a request.
  initial begin
    bit active;
    int cnt;
    active = 1'b0;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        cnt = 0;
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (stray_req) begin
        stray_req      = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {8{32'hDEAD_BEEF}};
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
        end
        if (cnt == mem_lat) begin
          active = 1'b0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) begin
            mem[bus.pmem_address] = bus.pmem_wdata;
            bus.pmem_rdata = '0;
          end else begin
            bus.pmem_rdata = mem.exists(bus.pmem_address) ? mem[bus.pmem_address] : fill(bus.pmem_address);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: checks every downstream request and every requester response against the queues.
  initial begin
    bit prev_act;
    bit act;
    bit side;
    int run;
    int cur_len;
    logic [AW-1:0] cur_addr;
    pm_exp_t pe;
    resp_exp_t re;
    prev_act = 1'b0;
    run = 0;
    cur_len = 0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      act = bus.pmem_read | bus.pmem_write;
      if (act && !prev_act) begin
        run = 1;
        if (pm_q.size() == 0) begin
          bad_event("pmem_unexpected");
          cur_len = 0;
        end else begin
          pe = pm_q.pop_front();
          chk("pmem_write", LW'(bus.pmem_write), LW'(pe.wr));
          chk("pmem_read", LW'(bus.pmem_read), LW'(!pe.wr));
          chk("pmem_addr", LW'(bus.pmem_address), LW'(pe.addr));
          if (pe.wr) chk("pmem_wdata", bus.pmem_wdata, pe.wdata);
          cur_len  = pe.len;
          cur_addr = pe.addr;
        end
      end else if (act) begin
        run++;
        if (bus.pmem_address !== cur_addr) chk("pmem_addr_stable", LW'(bus.pmem_address), LW'(cur_addr));
      end else if (prev_act && cur_len > 0) begin
        chk("pmem_len", LW'(run), LW'(cur_len));
      end

      if (bus.imem_resp && bus.dmem_resp) begin
        bad_event("resp_both");
      end else if (bus.imem_resp || bus.dmem_resp) begin
        side = bus.dmem_resp;
        if (resp_q.size() == 0) begin
          bad_event(side ? "dmem_resp_unexpected" : "imem_resp_unexpected");
        end else begin
          re = resp_q.pop_front();
          chk("resp_side", LW'(side), LW'(re.side));
          if (re.chk_data) chk("resp_data", side ? bus.dmem_rdata : bus.imem_rdata, re.data);
          chk("resp_after_pmem", LW'(prev_act), LW'(1));
          $display("txn %s resp addr_lo=%0h rdata_lo=%08h", side ? "D" : "I", cur_addr,
                   side ? bus.dmem_rdata[31:0] : bus.imem_rdata[31:0]);
        end
      end
      prev_act = act;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.imem_read = 1'b0;
    bus.imem_address = '0;
    bus.dmem_read = 1'b0;
    bus.dmem_write = 1'b0;
    bus.dmem_address = '0;
    bus.dmem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pmem_read", LW'(bus.pmem_read), '0);
    chk("rst_pmem_write", LW'(bus.pmem_write), '0);
    chk("rst_pmem_addr", LW'(bus.pmem_address), '0);
    chk("rst_imem_resp", LW'(bus.imem_resp), '0);
    chk("rst_dmem_resp", LW'(bus.dmem_resp), '0);
    chk("rst_imem_rdata", bus.imem_rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single I read, latency 10: request high 11 cycles.
    mem_lat = 10;
    pm_q.push_back('{1'b0, 32'h0000_0040, '0, 11});
    resp_q.push_back('{1'b0, 1'b1, {8{32'h5A5A_0040}}});
    i_txn(32'h0000_0040);
    @(negedge clk);

    // D write then read-back of the same line.
    mem_lat = 3;
    pm_q.push_back('{1'b1, 32'h0000_1000, {32{8'hA5}}, 4});
    resp_q.push_back('{1'b1, 1'b0, '0});
    d_txn(1'b0, 1'b1, 32'h0000_1000, {32{8'hA5}});
    pm_q.push_back('{1'b0, 32'h0000_1000, '0, 4});
    resp_q.push_back('{1'b1, 1'b1, {32{8'hA5}}});
    d_txn(1'b1, 1'b0, 32'h0000_1000, '0);
    chk("imem_rdata_hold", bus.imem_rdata, {8{32'h5A5A_0040}});

    // Read and write both high resolves to a write.
    pm_q.push_back('{1'b1, 32'h0000_1800, {8{32'h1234_5678}}, 4});
    resp_q.push_back('{1'b1, 1'b0, '0});
    d_txn(1'b1, 1'b1, 32'h0000_1800, {8{32'h1234_5678}});
    pm_q.push_back('{1'b0, 32'h0000_1800, '0, 4});
    resp_q.push_back('{1'b1, 1'b1, {8{32'h1234_5678}}});
    d_txn(1'b1, 1'b0, 32'h0000_1800, '0);
    @(negedge clk);

    // Continuous D traffic with I pending twice: D x4, I, D x2, I.
    mem_lat = 2;
    pm_q.push_back('{1'b0, 32'h0000_2000, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_2000}}});
    pm_q.push_back('{1'b0, 32'h0000_2020, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_2020}}});
    pm_q.push_back('{1'b0, 32'h0000_2040, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_2040}}});
    pm_q.push_back('{1'b0, 32'h0000_2060, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_2060}}});
    pm_q.push_back('{1'b0, 32'h0000_3000, '0, 3}); resp_q.push_back('{1'b0, 1'b1, {8{32'h5A5A_3000}}});
    pm_q.push_back('{1'b0, 32'h0000_2080, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_2080}}});
    pm_q.push_back('{1'b0, 32'h0000_20A0, '0, 3}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_20A0}}});
    pm_q.push_back('{1'b0, 32'h0000_3040, '0, 3}); resp_q.push_back('{1'b0, 1'b1, {8{32'h5A5A_3040}}});
    fork
      begin
        for (int k = 0; k < 6; k++) d_txn(1'b1, 1'b0, 32'h0000_2000 + 32'(k * 32), '0);
      end
      begin
        i_txn(32'h0000_3000);
        i_txn(32'h0000_3040);
      end
    join
    @(negedge clk);

    // I and D in the same cycle: D first, then I.
    mem_lat = 1;
    pm_q.push_back('{1'b0, 32'h0000_5000, '0, 2}); resp_q.push_back('{1'b1, 1'b1, {8{32'h5A5A_5000}}});
    pm_q.push_back('{1'b0, 32'h0000_4000, '0, 2}); resp_q.push_back('{1'b0, 1'b1, {8{32'h5A5A_4000}}});
    fork
      i_txn(32'h0000_4000);
      d_txn(1'b1, 1'b0, 32'h0000_5000, '0);
    join
    @(negedge clk);

    // Reset five cycles into a 10-cycle transaction.
    mem_lat = 10;
    pm_q.push_back('{1'b0, 32'h0000_6000, '0, 0});
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h0000_6000;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pmem_read", LW'(bus.pmem_read), '0);
    chk("rst_async_imem_resp", LW'(bus.imem_resp), '0);
    bus.imem_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_imem_rdata", bus.imem_rdata, '0);
    chk("rst_mid_dmem_rdata", bus.dmem_rdata, '0);
    rst = 1'b0;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    mem_lat = 2;
    pm_q.push_back('{1'b0, 32'h0000_0040, '0, 3});
    resp_q.push_back('{1'b0, 1'b1, {8{32'h5A5A_0040}}});
    i_txn(32'h0000_0040);

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", LW'(resp_q.size()), '0);
    chk("pmem_queue_empty", LW'(pm_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
